bootrom_obi_arbiter: RTL
========================

Name: bootrom_obi_arbiter

Overview:
- Shares the single boot ROM OBI subordinate port between NumMgr OBI managers, e.g. core instruction fetch and the debug/system-bus manager.
- Arbitration is round-robin, with a request lock held until grant.
- Each accepted transaction's manager index is stored in an in-order FIFO of depth MaxTrans, so R-channel responses route back to the correct manager.
- Sits between the crossbar manager ports and the boot ROM; ROM timing is gnt same cycle, rvalid next cycle.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by all ports.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- NumMgr, 2, number of upstream managers (>=2).
- MaxTrans, 2, maximum outstanding transactions (>=1); this is the routing FIFO depth.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- mgr_req_i  input  obi_req_t[NumMgr]  manager requests.
- mgr_rsp_o  output  obi_rsp_t[NumMgr]  manager responses.
- sbr_req_o  output  obi_req_t  request to the boot ROM.
- sbr_rsp_i  input  obi_rsp_t  response from the boot ROM.
- busy_o  output  1  high while any transaction is outstanding (cnt != 0).
- unexp_rsp_o  output  1  one-cycle pulse when rvalid arrives with the FIFO empty.

Behaviour:
- State registers: rr_ptr (clog2(NumMgr) bits), lock_q, lock_idx_q, FIFO storage, wr_ptr, rd_ptr, cnt (0..MaxTrans), unexp_rsp_o register.
- Reset: all state registers cleared to 0. While rst_i is high:
  - sbr_req_o.req=0;
  - all mgr_rsp_o gnt/rvalid=0;
  - busy_o=0, unexp_rsp_o=0.
- Arbitration (combinational):
  - If lock_q, winner = lock_idx_q.
  - Otherwise winner = first i with mgr_req_i[i].req, searching from rr_ptr upward modulo NumMgr.
- Forwarding:
  - sbr_req_o = mgr_req_i[winner] when some manager requests AND cnt < MaxTrans; otherwise sbr_req_o.req=0.
  - The A-channel fields are muxed from the winner, or zero when there is no winner.
- Grant: mgr_rsp_o[winner].gnt = sbr_rsp_i.gnt & sbr_req_o.req. All other gnt=0.
- Handshake hs = sbr_req_o.req & sbr_rsp_i.gnt. On hs:
  - push winner index into the FIFO;
  - rr_ptr <= (winner+1) mod NumMgr;
  - lock_q <= 0.
- Lock: if sbr_req_o.req & !sbr_rsp_i.gnt, then lock_q <= 1 and lock_idx_q <= winner. The selection stays fixed until the handshake (OBI A-channel stability).
- Full FIFO (cnt==MaxTrans):
  - no forwarding, no grants;
  - a pop in the same cycle does NOT allow a push in that cycle; acceptance resumes the next cycle.
- Response routing:
  - On sbr_rsp_i.rvalid with cnt>0, mgr_rsp_o[head].rvalid=1 and the FIFO is popped.
  - r fields (rdata, rid, err, r_optional) are broadcast to all managers; only the head manager sees rvalid.
- Unexpected response: rvalid with cnt==0 routes no rvalid, leaves cnt unchanged, and sets unexp_rsp_o=1 in the next cycle for exactly one cycle.
- Counter update:
  - cnt +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - wr_ptr and rd_ptr wrap modulo MaxTrans.
- Latency: zero added cycles on the A channel; the R channel is combinational pass-through. Back-to-back single-cycle handshakes are sustained when MaxTrans>=2.
- Reset asserted mid-transaction: outstanding entries are discarded. A ROM rvalid arriving after reset release is treated as unexpected.

Test Plan:
- Single manager 0 reads 0x0300_D000 (ROM gnt=req, rvalid+1) -> gnt0 in cycle 0; rvalid0 in cycle 1 with ROM data; rvalid1 stays 0; busy_o high for 1 cycle.
- Both managers request continuously for 4 cycles after reset -> grants in order 0,1,0,1; rvalid order matches the grant order, one cycle later each.
- ROM stub withholds gnt for 3 cycles while manager 0 waits, and manager 1 raises req in cycle 1 -> sbr_req_o stays on manager 0 (addr stable) until gnt; manager 1 is granted the next cycle.
- MaxTrans=2, ROM stub delays rvalid by 4 cycles, two managers requesting -> exactly 2 grants, then gnt=0 and sbr_req_o.req=0 until the first rvalid; the next grant comes the cycle after the pop.
- Inject rvalid with no outstanding transaction -> no mgr rvalid; unexp_rsp_o pulses for 1 cycle; cnt remains 0.
- Assert rst_i asynchronously mid-cycle with 2 transactions outstanding -> outputs drop immediately; after release, busy_o=0, rr_ptr=0, and manager 0 wins the first simultaneous request.

Source files
------------

// File: rtl/bootrom_obi_arbiter.sv
// Round-robin OBI arbiter sharing the boot ROM port between NumMgr managers.
// An in-order FIFO of granted manager indices steers each R-channel response back.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module bootrom_obi_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i,
  output logic     busy_o,
  output logic     unexp_rsp_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  localparam logic [IdxW-1:0] LastMgr = IdxW'(NumMgr - 1);
  localparam logic [IdxW:0]   NumMgrW = (IdxW + 1)'(NumMgr);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxTrans);

  if (NumMgr < 2 || MaxTrans < 1 || ObiCfg.AddrWidth == 0 || ObiCfg.DataWidth == 0) begin : g_bad_cfg
    $error("bootrom_obi_arbiter: illegal parameterisation");
  end

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unexp_q;

  logic [IdxW-1:0] winner, rr_win, cand, head;
  logic [IdxW:0]   sum;
  logic            found, win_valid, fwd, hs, pop;

  // Round-robin search from rr_ptr_q; a pending (ungranted) request pins the winner.
  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    found  = 1'b0;
    rr_win = rr_ptr_q;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < NumMgr; i++) begin
      sum = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
      if (sum >= NumMgrW) sum = sum - NumMgrW;
      cand = sum[IdxW-1:0];
      if (!found && mgr_req_i[cand].req) begin
        found  = 1'b1;
        rr_win = cand;
      end
    end
    winner    = lock_q ? lock_idx_q : rr_win;
    win_valid = lock_q ? mgr_req_i[lock_idx_q].req : found;
  end

  assign fwd  = win_valid & (cnt_q < FullCnt) & ~rst_i;
  assign hs   = fwd & sbr_rsp_i.gnt;
  assign head = fifo_q[rd_ptr_q];
  assign pop  = sbr_rsp_i.rvalid & (cnt_q != '0);

  always_comb begin
    sbr_req_o     = win_valid ? mgr_req_i[winner] : '0;
    sbr_req_o.req = fwd;
  end

  // R fields go to everyone; only the head-of-FIFO manager sees rvalid.
  always_comb begin
    for (int i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i]        = '0;
      mgr_rsp_o[i].r      = sbr_rsp_i.r;
      mgr_rsp_o[i].gnt    = hs & (winner == IdxW'(i));
      mgr_rsp_o[i].rvalid = pop & (head == IdxW'(i));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!hs && pop) cnt_d = cnt_q - 1'b1;
    rr_ptr_d = (winner == LastMgr) ? '0 : winner + 1'b1;
  end

  // NOTE: the routing FIFO is reset with the rest of the state so head is never X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      unexp_q    <= 1'b0;
    end else begin
      unexp_q <= sbr_rsp_i.rvalid & (cnt_q == '0);
      cnt_q   <= cnt_d;
      if (hs) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        rr_ptr_q         <= rr_ptr_d;
        lock_q           <= 1'b0;
      end else if (fwd) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign unexp_rsp_o = unexp_q;

endmodule
